cc_branch_cond: RTL
===================

# cc_branch_cond

Branch condition unit: consumes the 4-bit condition-code vector {V,C,N,Z} produced by the processor status register and resolves SPARC-style Bicc branches (16 conditions, annul bit) for the control unit. Accepts one branch request via a valid/ready handshake. Stalls one cycle when a flag-setting instruction is still writing the PSR. Returns taken/annul/target with a one-cycle response pulse and keeps a saturating taken-branch counter for debug.

## Interface
- DATAWIDTH_ALU_SELECTION, 4, width of flag vector {V,C,N,Z}
- DATAWIDTH_COND, 4, width of branch condition field
- DATAWIDTH_BUS, 32, width of branch target address
- DATAWIDTH_COUNT, 16, width of taken-branch counter
- CC_BRANCH_CLOCK_50  in  1  single system clock; all state updates on rising edge
- CC_BRANCH_RESET_InHigh  in  1  synchronous, active-high reset
- CC_BRANCH_PSR_IN  in  4  registered PSR flags, bit3 V, bit2 C, bit1 N, bit0 Z
- CC_BRANCH_SETCC_PENDING  in  1  flag write to PSR occurs at the coming edge
- CC_BRANCH_REQ_VALID  in  1  request present
- CC_BRANCH_REQ_READY  out  1  unit can accept a request
- CC_BRANCH_COND  in  4  Bicc cond field
- CC_BRANCH_ANNUL  in  1  instruction annul bit (a)
- CC_BRANCH_TARGET  in  32  branch target address
- CC_BRANCH_RESP_VALID  out  1  one-cycle result pulse
- CC_BRANCH_TAKEN  out  1  branch taken
- CC_BRANCH_ANNUL_SLOT  out  1  delay-slot instruction must be annulled
- CC_BRANCH_TARGET_OUT  out  32  latched target
- CC_BRANCH_TAKEN_COUNT  out  16  saturating count of taken branches

## Operation
- States: IDLE, WAIT_CC, EVAL, RESP.
- IDLE: REQ_READY=1. On REQ_VALID&REQ_READY, latch COND, ANNUL and TARGET.
  - If SETCC_PENDING=1 in the accept cycle, go to WAIT_CC; otherwise go to EVAL.
- WAIT_CC: one cycle, PSR now holds new flags; go to EVAL. SETCC_PENDING is ignored here.
- EVAL: compute taken from the current PSR_IN and latched COND, register the results, go to RESP.
- RESP: RESP_VALID=1 for exactly one cycle; go to IDLE. REQ_READY=0 in all states except IDLE.
- Condition map (cond: taken):
  - 0000 never; 0001 Z; 0010 Z|(N^V); 0011 N^V
  - 0100 C|Z; 0101 C; 0110 N; 0111 V
  - 1000 always; 1001–1111 are the complements of 0001–0111 respectively
- ANNUL_SLOT = ANNUL & (~taken | cond==1000).
- TARGET_OUT = latched target regardless of taken.
- TAKEN, ANNUL_SLOT and TARGET_OUT hold their values from RESP until the next RESP.
- TAKEN_COUNT increments by 1 when entering RESP with taken=1. It saturates at 0xFFFF and never wraps.

## Timing
- Reset (synchronous, sampled at edge):
  - State goes to IDLE.
  - TAKEN, ANNUL_SLOT, RESP_VALID and TAKEN_COUNT go to 0; TARGET_OUT goes to 0.
  - REQ_READY=0 while reset is asserted and 1 in the first cycle after it deasserts.
- Latency with the request accepted at edge k:
  - No pending flag write: RESP_VALID high in cycle k+2.
  - SETCC_PENDING at accept: RESP_VALID high in cycle k+3.
- Throughput: one request per 3 cycles (4 cycles with a stall); no back-to-back accept from RESP.
- REQ_VALID while REQ_READY=0 is ignored; the requester must hold the request.
- Reset mid-operation (WAIT_CC/EVAL/RESP): the transaction is dropped, no RESP_VALID is produced, and the counter is cleared.
- SETCC_PENDING outside IDLE has no effect on the current request.

## Structure
- Shared package cc_branch_pkg holds:
  - State encoding localparams (IDLE=2'd0, WAIT_CC=2'd1, EVAL=2'd2, RESP=2'd3).
  - Cond code constants (COND_BN … COND_BVC, COND_BA=4'b1000).
  - Flag bit indices (V=3, C=2, N=1, Z=0).
- One sub-module, cc_cond_eval: purely combinational, maps (flags[3:0], cond[3:0]) to taken. It is reusable by a future trap (Ticc) unit.
- Top-level module contains the FSM, the request/result registers and the saturating counter.

## Test plan
- All 16 conds × 16 flag vectors, no pending, ANNUL=0 -> TAKEN matches the map; RESP_VALID exactly at k+2; TARGET_OUT=TARGET.
- PSR_IN=4'b0000, SETCC_PENDING=1 at accept, PSR_IN becomes 4'b0001 next cycle, cond=0001 (be) -> response at k+3, TAKEN=1.
- Annul cases:
  - cond=1000, ANNUL=1 -> TAKEN=1, ANNUL_SLOT=1.
  - cond=0001, Z=0, ANNUL=1 -> TAKEN=0, ANNUL_SLOT=1.
  - cond=0001, Z=1, ANNUL=1 -> TAKEN=1, ANNUL_SLOT=0.
- REQ_VALID held high continuously -> accepts only in IDLE, one RESP every 3 cycles; a second request is not lost or duplicated.
- Preload counter to 0xFFFE by issuing taken branches; 3 more taken branches -> count 0xFFFF and stays there. Reset asserted in EVAL -> no RESP_VALID, count=0, REQ_READY=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/cc_branch_pkg.sv
// rtl/cc_branch_pkg.sv - shared encodings for the Bicc branch condition unit
package cc_branch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t WAIT_CC = 2'd1;
    localparam state_t EVAL    = 2'd2;
    localparam state_t RESP    = 2'd3;

    localparam logic [3:0] COND_BN   = 4'b0000;
    localparam logic [3:0] COND_BE   = 4'b0001;
    localparam logic [3:0] COND_BLE  = 4'b0010;
    localparam logic [3:0] COND_BL   = 4'b0011;
    localparam logic [3:0] COND_BLEU = 4'b0100;
    localparam logic [3:0] COND_BCS  = 4'b0101;
    localparam logic [3:0] COND_BNEG = 4'b0110;
    localparam logic [3:0] COND_BVS  = 4'b0111;
    localparam logic [3:0] COND_BA   = 4'b1000;
    localparam logic [3:0] COND_BNE  = 4'b1001;
    localparam logic [3:0] COND_BG   = 4'b1010;
    localparam logic [3:0] COND_BGE  = 4'b1011;
    localparam logic [3:0] COND_BGU  = 4'b1100;
    localparam logic [3:0] COND_BCC  = 4'b1101;
    localparam logic [3:0] COND_BPOS = 4'b1110;
    localparam logic [3:0] COND_BVC  = 4'b1111;

    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/cc_cond_eval.sv
// rtl/cc_cond_eval.sv - combinational Bicc/Ticc condition evaluator
module cc_cond_eval
    import cc_branch_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       taken
);

    logic v, c, n, z;
    logic base;

    assign v = flags[FLAG_V];
    assign c = flags[FLAG_C];
    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];

    // cond[3] inverts the lower-half test; "always" is the complement of "never"
    always_comb begin
        base = 1'b0;
        case (cond[2:0])
            COND_BN[2:0]:   base = 1'b0;
            COND_BE[2:0]:   base = z;
            COND_BLE[2:0]:  base = z | (n ^ v);
            COND_BL[2:0]:   base = n ^ v;
            COND_BLEU[2:0]: base = c | z;
            COND_BCS[2:0]:  base = c;
            COND_BNEG[2:0]: base = n;
            COND_BVS[2:0]:  base = v;
            default:        base = 1'b0;
        endcase
        taken = base ^ cond[3];
    end

endmodule

// File: rtl/cc_branch_cond.sv
// rtl/cc_branch_cond.sv - branch resolution FSM with PSR-write stall and taken counter
module cc_branch_cond
    import cc_branch_pkg::*;
#(
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int DATAWIDTH_COND          = 4,
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DATAWIDTH_COUNT         = 16
) (
    input  logic                               CC_BRANCH_CLOCK_50,
    input  logic                               CC_BRANCH_RESET_InHigh,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_BRANCH_PSR_IN,
    input  logic                               CC_BRANCH_SETCC_PENDING,
    input  logic                               CC_BRANCH_REQ_VALID,
    output logic                               CC_BRANCH_REQ_READY,
    input  logic [DATAWIDTH_COND-1:0]          CC_BRANCH_COND,
    input  logic                               CC_BRANCH_ANNUL,
    input  logic [DATAWIDTH_BUS-1:0]           CC_BRANCH_TARGET,
    output logic                               CC_BRANCH_RESP_VALID,
    output logic                               CC_BRANCH_TAKEN,
    output logic                               CC_BRANCH_ANNUL_SLOT,
    output logic [DATAWIDTH_BUS-1:0]           CC_BRANCH_TARGET_OUT,
    output logic [DATAWIDTH_COUNT-1:0]         CC_BRANCH_TAKEN_COUNT
);

    localparam logic [DATAWIDTH_COUNT-1:0] COUNT_ONE = 1;

    state_t                      state;
    state_t                      state_next;
    logic [DATAWIDTH_COND-1:0]   cond_q;
    logic                        annul_q;
    logic [DATAWIDTH_BUS-1:0]    target_q;
    logic                        eval_taken;
    logic                        accept;

    assign accept = CC_BRANCH_REQ_VALID & (state == IDLE);

    cc_cond_eval u_cond_eval (
        .flags (CC_BRANCH_PSR_IN),
        .cond  (cond_q),
        .taken (eval_taken)
    );

    always_ff @(posedge CC_BRANCH_CLOCK_50) begin
        if (CC_BRANCH_RESET_InHigh) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = CC_BRANCH_SETCC_PENDING ? WAIT_CC : EVAL;
                end
            end
            WAIT_CC: state_next = EVAL;
            EVAL:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        CC_BRANCH_REQ_READY  = 1'b0;
        CC_BRANCH_RESP_VALID = 1'b0;
        if (!CC_BRANCH_RESET_InHigh) begin
            CC_BRANCH_REQ_READY  = (state == IDLE);
            CC_BRANCH_RESP_VALID = (state == RESP);
        end
    end

    // Results are captured on the EVAL->RESP edge and held until the next response
    always_ff @(posedge CC_BRANCH_CLOCK_50) begin
        if (CC_BRANCH_RESET_InHigh) begin
            cond_q                <= '0;
            annul_q               <= 1'b0;
            target_q              <= '0;
            CC_BRANCH_TAKEN       <= 1'b0;
            CC_BRANCH_ANNUL_SLOT  <= 1'b0;
            CC_BRANCH_TARGET_OUT  <= '0;
            CC_BRANCH_TAKEN_COUNT <= '0;
        end else begin
            if (accept) begin
                cond_q   <= CC_BRANCH_COND;
                annul_q  <= CC_BRANCH_ANNUL;
                target_q <= CC_BRANCH_TARGET;
            end
            if (state == EVAL) begin
                CC_BRANCH_TAKEN      <= eval_taken;
                CC_BRANCH_ANNUL_SLOT <= annul_q & (~eval_taken | (cond_q == COND_BA));
                CC_BRANCH_TARGET_OUT <= target_q;
                if (eval_taken && (CC_BRANCH_TAKEN_COUNT != '1)) begin
                    CC_BRANCH_TAKEN_COUNT <= CC_BRANCH_TAKEN_COUNT + COUNT_ONE;
                end
            end
        end
    end

endmodule
